// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: streams a program into instruction memory, then owns CPU reset/enable (run, halt, resume, watchdog).
// Latency: memory write one cycle after each stream handshake; backpressure: in_ready is high only while a load is active.
module prog_load_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int START_ADR = 0,
    parameter int MAX_RUN   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              run_req,
    input  logic              halt_req,
    output logic [DATA_W-1:0] w_instruction,
    output logic [ADDR_W-1:0] w_adr,
    output logic              w_enable,
    output logic              cpu_en,
    output logic              cpu_resetn,
    output logic              load_done,
    output logic              load_err,
    output logic              timeout,
    output logic [31:0]       run_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_RUN    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] START   = ADDR_W'(START_ADR);
    localparam bit                WD_ON   = (MAX_RUN != 0);
    localparam logic [31:0]       WD_LAST = 32'(MAX_RUN) - 32'd1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_w_instruction;
    logic [ADDR_W-1:0]   r_w_adr;
    logic                r_w_enable;
    logic                r_cpu_en;
    logic                r_cpu_resetn;
    logic                r_load_done;
    logic                r_load_err;
    logic                r_timeout;
    logic [31:0]         r_run_cnt;

    logic                w_len_ok;
    logic                w_handshake;
    logic [31:0]         w_cnt_inc;

    assign w_len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    assign w_handshake = in_valid && r_in_ready;
    assign w_cnt_inc   = (&r_run_cnt) ? r_run_cnt : r_run_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= START;
            r_remaining     <= '0;
            r_in_ready      <= 1'b0;
            r_w_instruction <= '0;
            r_w_adr         <= '0;
            r_w_enable      <= 1'b0;
            r_cpu_en        <= 1'b0;
            r_cpu_resetn    <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_err      <= 1'b0;
            r_timeout       <= 1'b0;
            r_run_cnt       <= '0;
        end else begin
            r_w_enable  <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                // halt_req outranks both requests, so it simply blocks them here
                S_IDLE, S_LOADED, S_HALT: begin
                    if (!halt_req && start_load) begin
                        if (w_len_ok) begin
                            r_load_err   <= 1'b0;
                            r_ptr        <= START;
                            r_remaining  <= load_len;
                            r_run_cnt    <= '0;
                            r_in_ready   <= 1'b1;
                            r_cpu_en     <= 1'b0;
                            r_cpu_resetn <= 1'b0;
                            r_state      <= S_LOAD;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end else if (!halt_req && run_req && (r_state != S_IDLE)) begin
                        r_timeout    <= 1'b0;
                        r_cpu_en     <= 1'b1;
                        r_cpu_resetn <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (halt_req) begin
                        r_in_ready <= 1'b0;
                        r_load_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (w_handshake) begin
                        r_w_instruction <= in_data;
                        r_w_adr         <= r_ptr;
                        r_w_enable      <= 1'b1;
                        r_ptr           <= r_ptr + ADDR_W'(1);
                        r_remaining     <= r_remaining - (ADDR_W+1)'(1);
                        if (r_remaining == (ADDR_W+1)'(1)) begin
                            r_in_ready  <= 1'b0;
                            r_load_done <= 1'b1;
                            r_state     <= S_LOADED;
                        end
                    end
                end
                S_RUN: begin
                    r_run_cnt <= w_cnt_inc;
                    if (halt_req) begin
                        r_cpu_en <= 1'b0;
                        r_state  <= S_HALT;
                    end else if (WD_ON && (r_run_cnt >= WD_LAST)) begin
                        // >= keeps the budget per load: a resume after expiry gets one cycle
                        r_timeout <= 1'b1;
                        r_cpu_en  <= 1'b0;
                        r_state   <= S_HALT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign w_instruction = r_w_instruction;
    assign w_adr         = r_w_adr;
    assign w_enable      = r_w_enable;
    assign cpu_en        = r_cpu_en;
    assign cpu_resetn    = r_cpu_resetn;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;
    assign timeout       = r_timeout;
    assign run_cnt       = r_run_cnt;
    assign state         = r_state;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: instance 0 uses START_ADR=0 without watchdog, instance 1 uses START_ADR=2046 with MAX_RUN=8.
// Writes are scored against a queue of expected (address, data, last) entries built from the words offered.
module tb_prog_load_ctrl;

    typedef struct packed {
        logic [10:0] adr;
        logic [31:0] dat;
        logic        last;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start_load    [2];
    logic [11:0] load_len      [2];
    logic        in_valid      [2];
    logic [31:0] in_data       [2];
    logic        run_req       [2];
    logic        halt_req      [2];
    logic        in_ready      [2];
    logic [31:0] w_instruction [2];
    logic [10:0] w_adr         [2];
    logic        w_enable      [2];
    logic        cpu_en        [2];
    logic        cpu_resetn    [2];
    logic        load_done     [2];
    logic        load_err      [2];
    logic        timeout       [2];
    logic [31:0] run_cnt       [2];
    logic [2:0]  state         [2];

    int  n_checks = 0;
    int  n_errors = 0;
    int  m_cnt [2];
    wr_t q0[$];
    wr_t q1[$];

    prog_load_ctrl #(.ADDR_W(11), .DATA_W(32), .START_ADR(0), .MAX_RUN(0)) u0 (
        .clk(clk), .reset(reset), .start_load(start_load[0]), .load_len(load_len[0]),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .run_req(run_req[0]), .halt_req(halt_req[0]), .w_instruction(w_instruction[0]),
        .w_adr(w_adr[0]), .w_enable(w_enable[0]), .cpu_en(cpu_en[0]), .cpu_resetn(cpu_resetn[0]),
        .load_done(load_done[0]), .load_err(load_err[0]), .timeout(timeout[0]),
        .run_cnt(run_cnt[0]), .state(state[0])
    );

    prog_load_ctrl #(.ADDR_W(11), .DATA_W(32), .START_ADR(2046), .MAX_RUN(8)) u1 (
        .clk(clk), .reset(reset), .start_load(start_load[1]), .load_len(load_len[1]),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .run_req(run_req[1]), .halt_req(halt_req[1]), .w_instruction(w_instruction[1]),
        .w_adr(w_adr[1]), .w_enable(w_enable[1]), .cpu_en(cpu_en[1]), .cpu_resetn(cpu_resetn[1]),
        .load_done(load_done[1]), .load_err(load_err[1]), .timeout(timeout[1]),
        .run_cnt(run_cnt[1]), .state(state[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [10:0] exp_adr(input int k, input int idx);
        int base;
        base = (k == 1) ? 2046 : 0;
        return 11'((base + idx) % 2048);
    endfunction

    task automatic qpush(input int k, input wr_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic qpop(input int k, output wr_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Write scoreboard: every strobe must match the next expected word, never with cpu_en high.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            wr_t e;
            bit  ok;
            if (w_enable[k] === 1'b1) begin
                chk("wr_while_cpu_en", cpu_en[k], 0);
                qpop(k, e, ok);
                if (!ok) chk("wr_unexpected", w_enable[k], 0);
                else begin
                    chk("wr_adr", w_adr[k], e.adr);
                    chk("wr_dat", w_instruction[k], e.dat);
                    chk("wr_load_done", load_done[k], e.last);
                end
            end else if (load_done[k] === 1'b1) begin
                chk("load_done_no_wr", load_done[k], 0);
            end
        end
    end

    task automatic chk_rst(input int k);
        chk("rst_state", state[k], 0);
        chk("rst_in_ready", in_ready[k], 0);
        chk("rst_w_enable", w_enable[k], 0);
        chk("rst_w_adr", w_adr[k], 0);
        chk("rst_w_instr", w_instruction[k], 0);
        chk("rst_cpu_en", cpu_en[k], 0);
        chk("rst_cpu_resetn", cpu_resetn[k], 0);
        chk("rst_load_done", load_done[k], 0);
        chk("rst_load_err", load_err[k], 0);
        chk("rst_timeout", timeout[k], 0);
        chk("rst_run_cnt", run_cnt[k], 0);
    endtask

    // mode: 0 valid held high, 1 random valid, 2 alternate 1,0; base!=0 gives data base+idx.
    task automatic load(input int k, input int len, input int mode, input int abort_at, input logic [31:0] base);
        int          idx;
        int          cyc;
        logic        v;
        logic [31:0] d;
        wr_t         e;
        start_load[k] = 1'b1;
        load_len[k]   = 12'(len);
        tick();
        start_load[k] = 1'b0;
        m_cnt[k] = 0;
        chk("ld_state", state[k], 1);
        chk("ld_in_ready_first", in_ready[k], 1);
        chk("ld_err_clear", load_err[k], 0);
        chk("ld_run_cnt_clear", run_cnt[k], 0);
        chk("ld_cpu_en", cpu_en[k], 0);
        chk("ld_cpu_resetn", cpu_resetn[k], 0);
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 4 * len + 20) begin
            v = (mode == 0) ? 1'b1 : (mode == 2) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            d = (base != 0) ? base + 32'(idx) : $urandom;
            in_valid[k] = v;
            in_data[k]  = d;
            chk("ld_in_ready", in_ready[k], 1);
            if (v && idx == abort_at) begin
                halt_req[k] = 1'b1;
                tick();
                halt_req[k] = 1'b0;
                in_valid[k] = 1'b0;
                chk("abort_state", state[k], 0);
                chk("abort_err", load_err[k], 1);
                chk("abort_in_ready", in_ready[k], 0);
                chk("abort_w_enable", w_enable[k], 0);
                tick();
                chk("abort_q_empty", qsize(k), 0);
                return;
            end
            if (v) begin
                e.adr  = exp_adr(k, idx);
                e.dat  = d;
                e.last = (idx == len - 1);
                qpush(k, e);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid[k] = 1'b0;
        chk("ld_words_accepted", idx, len);
        chk("ld_end_state", state[k], 2);
        chk("ld_end_in_ready", in_ready[k], 0);
        chk("ld_end_cpu_en", cpu_en[k], 0);
        chk("ld_end_cpu_resetn", cpu_resetn[k], 0);
        tick();
        chk("ld_q_empty", qsize(k), 0);
    endtask

    // Start or resume, run n RUN cycles, halt in the n-th.
    task automatic run_halt(input int k, input int n);
        run_req[k] = 1'b1;
        tick();
        run_req[k] = 1'b0;
        chk("run_cpu_en", cpu_en[k], 1);
        chk("run_cpu_resetn", cpu_resetn[k], 1);
        chk("run_state", state[k], 3);
        chk("run_timeout_clear", timeout[k], 0);
        for (int i = 1; i < n; i++) begin
            tick();
            chk("run_hold_en", cpu_en[k], 1);
            chk("run_hold_resetn", cpu_resetn[k], 1);
        end
        halt_req[k] = 1'b1;
        tick();
        halt_req[k] = 1'b0;
        m_cnt[k] += n;
        chk("halt_cpu_en", cpu_en[k], 0);
        chk("halt_state", state[k], 4);
        chk("halt_cpu_resetn", cpu_resetn[k], 1);
        chk("halt_run_cnt", run_cnt[k], 64'(m_cnt[k]));
    endtask

    initial begin
        int en_cycles;
        int guard;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_load[k] = 1'b0;
            load_len[k]   = '0;
            in_valid[k]   = 1'b0;
            in_data[k]    = '0;
            run_req[k]    = 1'b0;
            halt_req[k]   = 1'b0;
            m_cnt[k]      = 0;
        end
        repeat (3) tick();
        chk_rst(0);
        chk_rst(1);
        reset = 1'b0;
        tick();

        run_req[0] = 1'b1;
        tick();
        run_req[0] = 1'b0;
        chk("idle_run_ignored", state[0], 0);

        start_load[0] = 1'b1;
        load_len[0]   = 12'd0;
        tick();
        start_load[0] = 1'b0;
        chk("len0_err", load_err[0], 1);
        chk("len0_state", state[0], 0);
        start_load[0] = 1'b1;
        load_len[0]   = 12'd2049;
        tick();
        start_load[0] = 1'b0;
        chk("len_big_err", load_err[0], 1);
        chk("len_big_state", state[0], 0);
        chk("len_big_in_ready", in_ready[0], 0);

        load(0, 4, 0, -1, 32'hA0);

        start_load[0] = 1'b1;
        load_len[0]   = 12'd0;
        tick();
        start_load[0] = 1'b0;
        chk("loaded_len0_err", load_err[0], 1);
        chk("loaded_len0_state", state[0], 2);

        run_halt(0, 10);
        run_halt(0, 5);

        halt_req[0]   = 1'b1;
        start_load[0] = 1'b1;
        load_len[0]   = 12'd3;
        tick();
        halt_req[0]   = 1'b0;
        start_load[0] = 1'b0;
        chk("prio_halt_over_load", state[0], 4);
        chk("prio_halt_resetn", cpu_resetn[0], 1);

        load(0, 3, 2, -1, 0);

        halt_req[0] = 1'b1;
        run_req[0]  = 1'b1;
        tick();
        halt_req[0] = 1'b0;
        run_req[0]  = 1'b0;
        chk("prio_loaded_state", state[0], 2);
        chk("prio_loaded_cpu_en", cpu_en[0], 0);
        run_req[0] = 1'b1;
        tick();
        chk("prio_run_state", state[0], 3);
        halt_req[0] = 1'b1;
        tick();
        halt_req[0] = 1'b0;
        run_req[0]  = 1'b0;
        chk("prio_run_halted", state[0], 4);
        chk("prio_run_cnt", run_cnt[0], 1);

        load(0, 5, 0, 1, 0);

        load(1, 3, 0, -1, 0);
        run_req[1] = 1'b1;
        tick();
        run_req[1] = 1'b0;
        en_cycles = 0;
        guard     = 0;
        while (cpu_en[1] === 1'b1 && guard < 40) begin
            en_cycles++;
            tick();
            guard++;
        end
        chk("wd_en_cycles", en_cycles, 8);
        chk("wd_timeout", timeout[1], 1);
        chk("wd_state", state[1], 4);
        chk("wd_run_cnt", run_cnt[1], 8);
        chk("wd_resetn", cpu_resetn[1], 1);
        run_req[1] = 1'b1;
        tick();
        run_req[1] = 1'b0;
        chk("wd_resume_timeout", timeout[1], 0);
        chk("wd_resume_en", cpu_en[1], 1);
        chk("wd_resume_state", state[1], 3);
        halt_req[1] = 1'b1;
        tick();
        halt_req[1] = 1'b0;
        chk("wd_halt_state", state[1], 4);
        chk("wd_halt_timeout", timeout[1], 0);

        load(1, $urandom_range(1, 6), $urandom_range(0, 2), -1, 0);
        run_halt(1, $urandom_range(1, 7));

        for (int it = 0; it < 6; it++) begin
            load(0, $urandom_range(1, 12), $urandom_range(0, 2), -1, 0);
            run_halt(0, $urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) run_halt(0, $urandom_range(1, 10));
        end

        load(0, 2048, 0, -1, 0);
        run_req[0] = 1'b1;
        tick();
        run_req[0] = 1'b0;
        repeat (3) tick();
        chk("pre_reset_en", cpu_en[0], 1);
        reset = 1'b1;
        tick();
        chk_rst(0);
        chk_rst(1);
        reset = 1'b0;
        tick();
        chk("post_reset_state", state[0], 0);
        chk("post_reset_resetn", cpu_resetn[0], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Boot/run sequencer for the pipelined CPU subsystem.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through the external write port (w_instruction/w_adr/w_enable).
- Then holds or releases CPU reset and drives cpu_en to start, halt, resume or time out execution.
- Sits between the host/test interface and the CPU top level; it is the sole owner of cpu_en.

Parameters:
- ADDR_W, 11, memory word-address width.
- DATA_W, 32, instruction word width.
- START_ADR, 0, first memory address written by a load.
- MAX_RUN, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock (rising edge).
- reset  in  1  synchronous, active-high reset.
- start_load  in  1  single-cycle request to begin a load.
- load_len  in  ADDR_W+1  number of words to load; sampled with start_load.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  controller accepts a word this cycle.
- run_req  in  1  start/resume request.
- halt_req  in  1  halt/abort request.
- w_instruction  out  DATA_W  memory write data.
- w_adr  out  ADDR_W  memory write address.
- w_enable  out  1  memory write strobe.
- cpu_en  out  1  CPU clock enable / memory-port select.
- cpu_resetn  out  1  CPU reset, active low.
- load_done  out  1  one-cycle pulse after the final word is written.
- load_err  out  1  sticky; cleared on the next accepted start_load.
- timeout  out  1  sticky; cleared on the next accepted run_req.
- run_cnt  out  32  RUN cycles since the last load (saturating).
- state  out  3  IDLE=0, LOAD=1, LOADED=2, RUN=3, HALT=4.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0 except cpu_resetn=0.
  - Internal ptr=START_ADR, remaining=0.
- IDLE: in_ready=0, cpu_en=0, cpu_resetn=0.
  - start_load with load_len=0 or load_len>2^ADDR_W: set load_err, stay IDLE.
  - Otherwise: clear load_err, ptr<=START_ADR, remaining<=load_len, run_cnt<=0, go to LOAD.
- LOAD: in_ready=1 (registered; high the cycle after entry).
  - Each in_valid&&in_ready handshake registers {w_instruction<=in_data, w_adr<=ptr, w_enable<=1} for exactly the next cycle, so write latency is 1 cycle.
  - ptr increments modulo 2^ADDR_W (wrap from 2^ADDR_W-1 to 0). remaining decrements.
  - On the handshake with remaining==1: in_ready deasserts the next cycle, load_done pulses in the same cycle as the final w_enable, and state goes to LOADED.
  - halt_req in LOAD: abort, set load_err, go to IDLE. A write already registered still completes; no further handshakes.
  - start_load and run_req are ignored in LOAD.
- LOADED: cpu_en=0, cpu_resetn=0.
  - run_req: go to RUN.
  - start_load: reload (same rules as IDLE).
- RUN: cpu_en=1, cpu_resetn=1, both registered (asserted the cycle after the transition).
  - run_cnt increments each RUN cycle and saturates at all-ones.
  - halt_req: go to HALT.
  - If MAX_RUN!=0 and run_cnt reaches MAX_RUN-1 while in RUN: set timeout, go to HALT. Exactly MAX_RUN cycles are spent with cpu_en=1.
  - start_load is ignored in RUN.
- HALT: cpu_en=0, cpu_resetn=1 (CPU state preserved).
  - run_req: clear timeout, resume in RUN; run_cnt continues counting.
  - start_load: cpu_resetn<=0, then LOAD rules apply.
- Priority when requests coincide: halt_req > start_load > run_req.
- w_enable is never asserted while cpu_en=1; the memory port mux depends on this.
- Reset asserted mid-load or mid-run: immediate return to reset values on the next edge, and any pending write is dropped.

Test Plan:
- Basic load: reset; start_load, load_len=4; stream 0xA0..0xA3 with in_valid held high → w_enable on 4 consecutive cycles at w_adr 0..3 carrying those data; load_done coincides with the 4th write; state=LOADED; cpu_resetn=0.
- Backpressure: load_len=3 with in_valid toggled 1,0,1,0,1 → exactly 3 writes, addresses contiguous, no write on idle cycles.
- Wrap and error:
  - START_ADR=2046, load_len=3 → writes at 2046, 2047, 0.
  - Separate run with load_len=0 → load_err=1, state stays IDLE, no w_enable.
- Run/halt/resume: after load, run_req → cpu_en=1, cpu_resetn=1 the next cycle; halt_req after 10 cycles → cpu_en=0, run_cnt=10; run_req → resume, with cpu_resetn never dropping.
- Watchdog: MAX_RUN=8; run_req → cpu_en high exactly 8 cycles, then timeout=1, state=HALT; run_req clears timeout.
- Abort and priority:
  - halt_req during word 2 of a 5-word load → IDLE, load_err=1, only the registered writes complete.
  - halt_req with run_req in LOADED-then-RUN → halt wins.
  - Reset during RUN → all outputs at reset values on the next cycle.
